// File: rtl/systolic_ctrl_pkg.sv
// rtl/systolic_ctrl_pkg.sv - shared state encoding and phase-length helpers for systolic_ctrl
package systolic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    READ  = 2'd3
  } state_t;

  // Last operand enters at DIM-1 and needs 2*(DIM-1) more hops to reach the far corner PE.
  function automatic int feed_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

  function automatic int clear_cycles(input int dim);
    return dim;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew.sv
// rtl/systolic_ctrl_skew.sv - sa_skew: triangular delay line, lane n delayed n cycles
module sa_skew #(
  parameter int W   = 8,
  parameter int DIM = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIM-1:0][W-1:0] din,
  output logic [DIM-1:0][W-1:0] dout
);

  assign dout[0] = din[0];

  for (genvar n = 1; n < DIM; n++) begin : g_lane
    logic [W-1:0] taps [n];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < n; s++) taps[s] <= '0;
      end else begin
        taps[0] <= din[n];
        for (int s = 1; s < n; s++) taps[s] <= taps[s-1];
      end
    end

    assign dout[n] = taps[n-1];
  end

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - CLEAR/FEED/READ sequencer for a DIMxDIM systolic MAC array
// Optional SYSTOLIC_CTRL_ACCUM_EN: accum=1 at start skips CLEAR so products add onto C.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          accum,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(DIM)-1:0]        k_idx,
  input  logic [DIM-1:0][BITS_AB-1:0]   a_col,
  input  logic [DIM-1:0][BITS_AB-1:0]   b_row,
  output logic                          sa_en,
  output logic                          sa_WrEn,
  output logic [$clog2(DIM)-1:0]        sa_Crow,
  output logic [DIM-1:0][BITS_C-1:0]    sa_Cin,
  output logic [DIM-1:0][BITS_AB-1:0]   sa_A,
  output logic [DIM-1:0][BITS_AB-1:0]   sa_B,
  input  logic [DIM-1:0][BITS_C-1:0]    sa_Cout,
  output logic [DIM-1:0][BITS_C-1:0]    c_data,
  output logic [$clog2(DIM)-1:0]        c_row,
  output logic                          c_valid,
  input  logic                          c_ready
);

  localparam int RW     = $clog2(DIM);
  localparam int FEED_N = feed_cycles(DIM);
  localparam int CW     = $clog2(FEED_N + 1);

  localparam logic [CW-1:0] CLEAR_LAST = CW'(clear_cycles(DIM) - 1);
  localparam logic [CW-1:0] FEED_LAST  = CW'(FEED_N - 1);
  localparam logic [CW-1:0] ROW_LAST   = CW'(DIM - 1);
  localparam logic [CW-1:0] K_LIMIT    = CW'(DIM);
  localparam logic [RW-1:0] K_HOLD     = RW'(DIM - 1);

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [CW-1:0]               cnt_next;
  logic                        skip_clear;
  logic                        feed_live;
  logic [DIM-1:0][BITS_AB-1:0] a_in;
  logic [DIM-1:0][BITS_AB-1:0] b_in;

`ifdef SYSTOLIC_CTRL_ACCUM_EN
  assign skip_clear = accum;
`else
  logic unused_accum;
  assign unused_accum = accum;
  assign skip_clear   = 1'b0;
`endif

  assign cnt_next  = cnt + CW'(1);
  assign feed_live = (state == FEED) && (cnt < K_LIMIT);

  // Once all DIM operand slices are in, zeros flush the array so stale data never multiplies.
  assign a_in = feed_live ? a_col : '0;
  assign b_in = feed_live ? b_row : '0;

  sa_skew #(.W(BITS_AB), .DIM(DIM)) u_skew_a (
    .clk  (clk),
    .rst  (rst),
    .din  (a_in),
    .dout (sa_A)
  );

  sa_skew #(.W(BITS_AB), .DIM(DIM)) u_skew_b (
    .clk  (clk),
    .rst  (rst),
    .din  (b_in),
    .dout (sa_B)
  );

  assign sa_Cin = '0;
  assign c_data = c_valid ? sa_Cout : '0;
  assign done   = (state == READ) && c_ready && (cnt == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      sa_en   <= 1'b0;
      sa_WrEn <= 1'b0;
      sa_Crow <= '0;
      k_idx   <= '0;
      c_row   <= '0;
      c_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            if (skip_clear) begin
              state <= FEED;
              sa_en <= 1'b1;
            end else begin
              state   <= CLEAR;
              sa_WrEn <= 1'b1;
            end
          end
        end

        CLEAR: begin
          if (cnt == CLEAR_LAST) begin
            state   <= FEED;
            cnt     <= '0;
            sa_WrEn <= 1'b0;
            sa_Crow <= '0;
            sa_en   <= 1'b1;
            k_idx   <= '0;
          end else begin
            cnt     <= cnt_next;
            sa_Crow <= cnt_next[RW-1:0];
          end
        end

        FEED: begin
          if (cnt == FEED_LAST) begin
            state   <= READ;
            cnt     <= '0;
            sa_en   <= 1'b0;
            k_idx   <= '0;
            sa_Crow <= '0;
            c_row   <= '0;
            c_valid <= 1'b1;
          end else begin
            cnt   <= cnt_next;
            k_idx <= (cnt_next < K_LIMIT) ? cnt_next[RW-1:0] : K_HOLD;
          end
        end

        READ: begin
          if (c_ready) begin
            if (cnt == ROW_LAST) begin
              state   <= IDLE;
              cnt     <= '0;
              busy    <= 1'b0;
              c_valid <= 1'b0;
              c_row   <= '0;
              sa_Crow <= '0;
            end else begin
              cnt     <= cnt_next;
              c_row   <= cnt_next[RW-1:0];
              sa_Crow <= cnt_next[RW-1:0];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - scoreboard bench for systolic_ctrl with a behavioural MAC array
module tb_systolic_ctrl;

  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int DIM     = 8;
  localparam int RW      = $clog2(DIM);
  localparam int FEED_N  = 3 * DIM - 2;
  localparam int BOUND   = 200;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  logic                        clk, rst, start, accum, busy, done;
  logic [RW-1:0]               k_idx, sa_Crow, c_row;
  logic [DIM-1:0][BITS_AB-1:0] a_col, b_row, sa_A, sa_B;
  logic                        sa_en, sa_WrEn, c_valid, c_ready;
  logic [DIM-1:0][BITS_C-1:0]  sa_Cin, sa_Cout, c_data;

  systolic_ctrl #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .accum(accum), .busy(busy), .done(done),
    .k_idx(k_idx), .a_col(a_col), .b_row(b_row), .sa_en(sa_en), .sa_WrEn(sa_WrEn),
    .sa_Crow(sa_Crow), .sa_Cin(sa_Cin), .sa_A(sa_A), .sa_B(sa_B), .sa_Cout(sa_Cout),
    .c_data(c_data), .c_row(c_row), .c_valid(c_valid), .c_ready(c_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand matrices and the array model standing in for the external MAC grid.
  int ma [DIM][DIM];
  int mb [DIM][DIM];
  logic [BITS_C-1:0]         arr_c [DIM][DIM];
  logic signed [BITS_AB-1:0] arr_a [DIM][DIM];
  logic signed [BITS_AB-1:0] arr_b [DIM][DIM];

  always_comb begin
    a_col = '0;
    b_row = '0;
    for (int i = 0; i < DIM; i++) begin
      a_col[i] = BITS_AB'(ma[i][k_idx]);
      b_row[i] = BITS_AB'(mb[k_idx][i]);
    end
  end

  always_comb begin
    sa_Cout = '0;
    for (int j = 0; j < DIM; j++) sa_Cout[j] = arr_c[sa_Crow][j];
  end

  function automatic logic signed [BITS_AB-1:0] pe_a(input int i, input int j);
    if (j == 0) return sa_A[i];
    return arr_a[i][j-1];
  endfunction

  function automatic logic signed [BITS_AB-1:0] pe_b(input int i, input int j);
    if (i == 0) return sa_B[j];
    return arr_b[i-1][j];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          arr_a[i][j] <= '0;
          arr_b[i][j] <= '0;
        end
    end else begin
      if (sa_WrEn)
        for (int j = 0; j < DIM; j++) arr_c[sa_Crow][j] <= sa_Cin[j];
      if (sa_en)
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++) begin
            arr_c[i][j] <= arr_c[i][j] + BITS_C'(int'(pe_a(i, j)) * int'(pe_b(i, j)));
            arr_a[i][j] <= pe_a(i, j);
            arr_b[i][j] <= pe_b(i, j);
          end
    end
  end

  // Scoreboard
  typedef struct {
    int                         row;
    logic [DIM-1:0][BITS_C-1:0] data;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  logic [BITS_C-1:0] ref_c [DIM][DIM];

  logic                       prev_stall = 1'b0;
  logic [RW-1:0]              prev_row;
  logic [DIM-1:0][BITS_C-1:0] prev_data;

  always @(negedge clk) begin
    if (!rst && c_valid) begin
      if (prev_stall) begin
        chk("stall_row", c_row, prev_row);
        chk("stall_data", c_data, prev_data);
      end
      if (c_ready) begin
        chk("row_expected", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          mon_e = sbq.pop_front();
          chk("row_idx", c_row, mon_e.row);
          chk("row_data", c_data, mon_e.data);
        end
      end
    end
    prev_stall = !rst && c_valid && !c_ready;
    prev_row   = c_row;
    prev_data  = c_data;
  end

  bit bp_mode = 1'b0;
  int ph = 0;
  initial begin
    c_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        c_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        c_ready = 1'b1;
      end
    end
  end

  // mode: 0 all ones, 1 identity x ramp, 2 signed wrap, 3 random
  task automatic run_case(input int mode, input bit acc, input bit bp, input bit pulse, input bit abort);
    bit   skip;
    bit   fin;
    int   fs, f, exp_done, sum;
    exp_t e;
    logic [DIM-1:0][BITS_AB-1:0] ea, eb;

    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < DIM; k++) begin
        case (mode)
          0:       begin ma[i][k] = 1;                      mb[i][k] = 1; end
          1:       begin ma[i][k] = (i == k) ? 1 : 0;       mb[i][k] = i * 8 + k; end
          2:       begin ma[i][k] = -128;                   mb[i][k] = 127; end
          default: begin ma[i][k] = $urandom_range(0, 255) - 128; mb[i][k] = $urandom_range(0, 255) - 128; end
        endcase
      end

    skip = acc && ACC_ON;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        sum = skip ? int'($signed(ref_c[i][j])) : 0;
        for (int k = 0; k < DIM; k++) sum += ma[i][k] * mb[k][j];
        ref_c[i][j] = BITS_C'(sum);
        e.data[j]   = ref_c[i][j];
      end
      e.row = i;
      sbq.push_back(e);
    end

    fs       = skip ? 1 : DIM + 1;
    exp_done = fs + FEED_N + DIM - 1;
    bp_mode  = bp;
    fin      = 1'b0;

    @(posedge clk);
    #1 start = 1'b1;
    accum = acc;
    @(posedge clk);
    #1 start = 1'b0;
    accum = 1'b0;

    for (int cyc = 1; cyc <= BOUND && !fin; cyc++) begin
      @(negedge clk);
      chk("busy", busy, 1);
      if (!skip && cyc <= DIM) begin
        chk("clr_wren", sa_WrEn, 1);
        chk("clr_row", sa_Crow, cyc - 1);
        chk("clr_en", sa_en, 0);
      end
      f = cyc - fs;
      if (f >= 0 && f < FEED_N) begin
        chk("feed_en", sa_en, 1);
        chk("feed_wren", sa_WrEn, 0);
        chk("feed_k", k_idx, (f < DIM) ? f : DIM - 1);
        ea = '0;
        eb = '0;
        for (int i = 0; i < DIM; i++)
          if (f - i >= 0 && f - i < DIM) begin
            ea[i] = BITS_AB'(ma[i][f-i]);
            eb[i] = BITS_AB'(mb[f-i][i]);
          end
        chk("skew_a", sa_A, ea);
        chk("skew_b", sa_B, eb);
        chk("skew_a3", sa_A[3], ea[3]);
      end
      if (f == FEED_N) begin
        chk("read_valid", c_valid, 1);
        chk("read_en", sa_en, 0);
        chk("read_row0", c_row, 0);
      end
      if (pulse && f == 3) start = 1'b1;
      if (pulse && f == 4) start = 1'b0;
      if (abort && f == 5) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_en", sa_en, 0);
        chk("abort_k", k_idx, 0);
        chk("abort_sa_a", sa_A, 0);
        chk("abort_sa_b", sa_B, 0);
        chk("abort_valid", c_valid, 0);
        rst = 1'b0;
        sbq.delete();
        return;
      end
      if (done) begin
        if (!bp) chk("done_cycle", cyc, exp_done);
        chk("done_row", c_row, DIM - 1);
        fin = 1'b1;
      end
    end
    chk("timeout", fin, 1);

    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_pulse", done, 0);
    chk("sb_empty", sbq.size(), 0);
    if (pulse)
      repeat (3) begin
        @(negedge clk);
        chk("no_queued_start", busy, 0);
      end
    sbq.delete();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    accum = 1'b0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
        ref_c[i][j] = '0;
        arr_c[i][j] = '0;
      end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", sa_en, 0);
    chk("rst_wren", sa_WrEn, 0);
    chk("rst_crow", sa_Crow, 0);
    chk("rst_k", k_idx, 0);
    chk("rst_valid", c_valid, 0);
    chk("rst_row", c_row, 0);
    chk("rst_data", c_data, 0);
    chk("rst_cin", sa_Cin, 0);
    chk("rst_sa_b", sa_B, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_case(0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case(1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case(2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case(3, 1'b0, 1'b1, 1'b0, 1'b0);
    run_case(0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_case(0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_case(0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case(3, 1'b0, 1'b0, 1'b1, 1'b0);
    run_case(0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case(0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_case(3, 1'b1, 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
